// File: rtl/multiplier_pkg.sv
// Shared types and constants for the multiplier/NTT datapath family,
// including the Barrett reducer configuration and stage records.
package multiplier_pkg;

    localparam int DATA_LENGTH    = 64;
    localparam int BARRETT_STAGES = 4;
    localparam int BARRETT_TAG_W  = 4;
    localparam int BARRETT_K_W    = $clog2(DATA_LENGTH) + 1;
    localparam int BARRETT_MU_W   = DATA_LENGTH + 1;

    typedef struct packed {
        logic [DATA_LENGTH-1:0]  m;
        logic [BARRETT_MU_W-1:0] mu;
        logic [BARRETT_K_W-1:0]  k;
    } barrett_cfg_t;

    typedef struct packed {
        logic                     valid;
        logic [2*DATA_LENGTH-1:0] x;
        logic [DATA_LENGTH:0]     t;
        logic [BARRETT_TAG_W-1:0] tag;
        logic                     err;
    } barrett_stage_t;

    // Bit length of m, i.e. the k that pairs with it in a Barrett config.
    function automatic int k_of(input logic [DATA_LENGTH-1:0] m);
        int k;
        k = 0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (m[i]) k = i + 1;
        end
        return k;
    endfunction

endpackage

// File: rtl/barrett_corr.sv
// Final Barrett correction: brings a residue known to be below 3m into [0, m)
// with at most two conditional subtractions.
module barrett_corr #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH+1:0] a_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] r_o
);

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] c1;
    logic [WIDTH+1:0] c2;

    always_comb begin
        m_ext = {2'b00, m_i};
        c1    = a_i;
        if (c1 >= m_ext) c1 = c1 - m_ext;
        c2 = c1;
        if (c2 >= m_ext) c2 = c2 - m_ext;
        r_o = WIDTH'(c2);
    end

endmodule

// File: rtl/barrett_pipe.sv
// Four-stage streaming Barrett reducer, r = x mod m, with a modulus that is
// reprogrammed only while the pipeline is empty. Whole-pipe stall on backpressure.
module barrett_pipe
    import multiplier_pkg::*;
#(
    parameter int WIDTH = DATA_LENGTH,
    parameter int TAG_W = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_valid_i,
    output logic                         cfg_ready_o,
    input  logic [WIDTH-1:0]             cfg_m_i,
    input  logic [WIDTH:0]               cfg_mu_i,
    input  logic [$clog2(WIDTH):0]       cfg_k_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [2*WIDTH-1:0]           in_x_i,
    input  logic [TAG_W-1:0]             in_tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [WIDTH-1:0]             out_r_o,
    output logic [TAG_W-1:0]             out_tag_o,
    output logic                         out_err_o,
    output logic                         busy_o
);

    localparam int KW = $clog2(WIDTH) + 1;
    localparam int TW = WIDTH + 1;
    localparam int PW = 2 * WIDTH + 2;
    localparam int RW = WIDTH + 2;

    localparam logic [KW-1:0] ONE_K  = 1;
    localparam logic [KW:0]   ONE_K1 = 1;
    localparam logic [KW:0]   TWO_K1 = 2;
    localparam logic [RW:0]   ONE_R1 = 1;

    // Residues only ever need k+2 bits; everything above is discarded.
    function automatic logic [RW-1:0] low_mask(input logic [KW-1:0] k);
        logic [RW:0] lim;
        lim = ONE_R1 << ({1'b0, k} + TWO_K1);
        return RW'(lim - ONE_R1);
    endfunction

    barrett_cfg_t     cfg_q;
    logic [WIDTH-1:0] m_q;
    logic [TW-1:0]    mu_q;
    logic [KW-1:0]    k_q;

    assign m_q  = WIDTH'(cfg_q.m);
    assign mu_q = TW'(cfg_q.mu);
    assign k_q  = KW'(cfg_q.k);

    logic en;
    logic accept;
    logic cfg_load;
    logic vld_p1, vld_p2, vld_p3, vld_p4;

    assign en          = !vld_p4 || out_ready_i;
    assign in_ready_o  = en && !cfg_valid_i;
    assign accept      = in_valid_i && in_ready_o;
    assign busy_o      = vld_p1 || vld_p2 || vld_p3 || vld_p4;
    assign cfg_ready_o = !busy_o;
    assign cfg_load    = cfg_valid_i && cfg_ready_o;

    // Stage 1: quotient estimate input and range check
    logic [KW-1:0]   k_m1;
    logic [KW:0]     k_x2;
    logic [TW-1:0]   t_in;
    logic            err_in;

    assign k_m1   = k_q - ONE_K;
    assign k_x2   = {k_q, 1'b0};
    assign t_in   = TW'(in_x_i >> k_m1);
    assign err_in = |(in_x_i >> k_x2);

    logic [RW-1:0]    x_p1;
    logic [TW-1:0]    t_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             err_p1;

    // Stage 2: t * mu
    logic [RW-1:0]    x_p2;
    logic [PW-1:0]    prod_p2;
    logic [TAG_W-1:0] tag_p2;
    logic             err_p2;

    // Stage 3: q = p1 >> (k+1), q * m truncated to the residue width
    logic [KW:0]      k_p1;
    logic [TW-1:0]    q_s3;

    assign k_p1 = {1'b0, k_q} + ONE_K1;
    assign q_s3 = TW'(prod_p2 >> k_p1);

    logic [RW-1:0]    x_p3;
    logic [RW-1:0]    qm_p3;
    logic [TAG_W-1:0] tag_p3;
    logic             err_p3;

    // Stage 4: residue and final corrections
    logic [RW-1:0]    r_s4;
    logic [WIDTH-1:0] r_fix;

    assign r_s4 = (x_p3 - qm_p3) & low_mask(k_q);

    barrett_corr #(
        .WIDTH(WIDTH)
    ) u_corr (
        .a_i(r_s4),
        .m_i(m_q),
        .r_o(r_fix)
    );

    logic [WIDTH-1:0] r_p4;
    logic [TAG_W-1:0] tag_p4;
    logic             err_p4;

    always_ff @(posedge clk_i) begin
        if (en) begin
            x_p1    <= RW'(in_x_i);
            t_p1    <= t_in;
            tag_p1  <= in_tag_i;
            err_p1  <= err_in;

            x_p2    <= x_p1;
            prod_p2 <= PW'(t_p1) * PW'(mu_q);
            tag_p2  <= tag_p1;
            err_p2  <= err_p1;

            x_p3    <= x_p2;
            qm_p3   <= RW'(RW'(q_s3) * RW'(m_q));
            tag_p3  <= tag_p2;
            err_p3  <= err_p2;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q  <= '0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            vld_p4 <= 1'b0;
            r_p4   <= '0;
            tag_p4 <= '0;
            err_p4 <= 1'b0;
        end else begin
            if (cfg_load) begin
                cfg_q.m  <= DATA_LENGTH'(cfg_m_i);
                cfg_q.mu <= BARRETT_MU_W'(cfg_mu_i);
                cfg_q.k  <= BARRETT_K_W'(cfg_k_i);
            end
            if (en) begin
                vld_p1 <= accept;
                vld_p2 <= vld_p1;
                vld_p3 <= vld_p2;
                vld_p4 <= vld_p3;
                r_p4   <= r_fix;
                tag_p4 <= tag_p3;
                err_p4 <= err_p3 && vld_p3;
            end
        end
    end

    assign out_valid_o = vld_p4;
    assign out_r_o     = r_p4;
    assign out_tag_o   = tag_p4;
    assign out_err_o   = err_p4;

endmodule

// File: doc/barrett_pipe.md
Name: barrett_pipe

Overview:
- Pipelined, streaming Barrett modular reducer with a runtime-programmable modulus. Successor to the combinational barrett_parallel.
- Accepts one 2W-bit operand per cycle and returns x mod m after a fixed 4-cycle latency.
- Uses valid/ready flow control with full-pipeline stall on backpressure.
- Sits behind the NTT/multiplier datapath in multiplier_pkg designs: Dilithium, Kyber, generic moduli.

Parameters:
- WIDTH, 64: modulus width W; operand x is 2*WIDTH bits. Default equals DATA_LENGTH.
- TAG_W, 4: width of the sideband tag passed through alongside each operand.

Ports:
- clk_i  in  1  rising-edge clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_valid_i  in  1  request to load modulus configuration.
- cfg_ready_o  out  1  configuration accepted this cycle when cfg_valid_i=1 and cfg_ready_o=1.
- cfg_m_i  in  WIDTH  modulus m; must be odd and >2.
- cfg_mu_i  in  WIDTH+1  mu = floor(2^(2k)/m).
- cfg_k_i  in  $clog2(WIDTH)+1  k = bit length of m, range 2..WIDTH.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  operand accepted when in_valid_i & in_ready_o.
- in_x_i  in  2*WIDTH  operand x.
- in_tag_i  in  TAG_W  sideband tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer ready.
- out_r_o  out  WIDTH  x mod m.
- out_tag_o  out  TAG_W  tag of the operand.
- out_err_o  out  1  operand was out of range (x >= 2^(2k)).
- busy_o  out  1  at least one pipeline stage holds valid data.

Behaviour:
- Reset (async, rst_ni=0):
  - All stage valid bits, out_valid_o, out_err_o and busy_o cleared.
  - out_r_o, out_tag_o zeroed.
  - Config registers: m=0, mu=0, k=0.
  - cfg_ready_o=1 immediately after reset deassertion.
  - Reset mid-operation discards all in-flight operands; nothing is emitted.
- Global enable: en = !out_valid_o | out_ready_i. When en=0 every stage holds its contents.
- Input handshake: in_ready_o = en & !cfg_valid_i. Configuration has priority over data in the same cycle.
- Config handshake: cfg_ready_o = !busy_o. Configuration loads only when the pipeline is fully drained.
- The loaded config is used for all subsequently accepted operands. Operands with no config ever loaded produce undefined out_r_o; no other requirement applies.
- Stage 1 (on accept):
  - Register x, tag.
  - t1 = x >> (k-1), computed with a variable shift.
  - err = |(x >> 2k).
- Stage 2: p1 = t1 * mu, full product of width 2*WIDTH+2.
- Stage 3: q = p1 >> (k+1); p2 = q * m. Only the low k+2 bits of p2 are kept.
- Stage 4:
  - r = (x - p2) mod 2^(k+2).
  - If r >= m, subtract m; repeat once more (at most two corrections).
  - Drive out_r_o, out_tag_o, out_err_o.
- Latency: an operand accepted in cycle n appears with out_valid_o=1 in cycle n+4 if out_ready_i has been high throughout. Throughput is one result per cycle.
- When err=1, out_r_o is unspecified but out_tag_o is still correct.
- Ordering: results are emitted strictly in acceptance order. No drops or duplicates under arbitrary out_ready_i patterns.
- With out_ready_i held low, at most 4 operands are in flight. in_ready_o deasserts as soon as out_valid_o=1 and out_ready_i=0.
- Simultaneous out_ready_i rise and in_valid_i: accept and emit in the same cycle.

Decomposition:
- multiplier_pkg gains:
  - BARRETT_STAGES=4
  - barrett_cfg_t struct {m, mu, k}
  - barrett_stage_t struct {valid, x, t, tag, err}
  - function k_of(m) for bench use
- One sub-module, barrett_corr. It is combinational: two conditional subtractions of m from a (k+2)-bit value, used in stage 4.

Test Plan:
- Dilithium config: m=0x7FE001, mu=0x802007, k=23. Stream x = 0x7FE001, 0x7FE000, 0x12345678, 0x3FE004000000 back to back. Required r = 0x0, 0x7FE000, 0x38D654, 0x1, in order, each 4 cycles after its accept, with tags preserved.
- Kyber reconfigure: drain the pipeline, then load m=0xD01, mu=0x13AF, k=12. Send x=0xFFFFFF -> r=0x950. Send x=0x1000000 -> out_err_o=1.
- Backpressure: hold out_ready_i=0 while offering 6 operands. Exactly 4 are accepted and in_ready_o stays 0. Release out_ready_i: 4 results drain in order, then the remaining 2 are accepted.
- Config while busy: assert cfg_valid_i while 2 operands are in flight. cfg_ready_o=0 until busy_o falls. In-flight results use the old modulus.
- Reset mid-stream: assert rst_ni=0 with 3 operands in flight. out_valid_o and busy_o drop asynchronously, and no result is emitted after release.
- Random soak: 10k random x < 2^46 with random out_ready_i, compared against x % m. Zero mismatches.
